ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv_pkg.sv | 22 ++
 rtl/muldiv_iter.sv | 74 +++++++
 rtl/ex_muldiv.sv | 143 ++++++++++++++
 tb/tb_ex_muldiv.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the RV32M multiply/divide unit: op encodings, FSM states, sizes.
package ex_muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring divide, one bit per step.
module muldiv_iter
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [DATA_W-1:0]   mag_a,
  input  logic [DATA_W-1:0]   mag_b,
  output logic                last,
  output logic [2*DATA_W-1:0] prod,
  output logic [DATA_W-1:0]   quot,
  output logic [DATA_W-1:0]   rem
);

  localparam int CNT_W = $clog2(ITER);

  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q, acc_nxt;
  logic [DATA_W-1:0]   quot_q, quot_nxt;
  logic [DATA_W:0]     rem_q, rem_nxt;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W+1:0]   rem_sh, rem_diff;

  // Multiply: low half of acc holds the multiplier, consumed LSB first as the sum shifts in.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_nxt = {mul_sum, acc_q[DATA_W-1:1]};
  end

  // Divide: dividend shifts out of quot MSB first into the partial remainder.
  always_comb begin
    rem_sh   = {rem_q, quot_q[DATA_W-1]};
    rem_diff = rem_sh - {2'b00, opb_q};
    if (rem_diff[DATA_W+1]) begin
      rem_nxt  = rem_sh[DATA_W:0];
      quot_nxt = {quot_q[DATA_W-2:0], 1'b0};
    end else begin
      rem_nxt  = rem_diff[DATA_W:0];
      quot_nxt = {quot_q[DATA_W-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      opb_q  <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      acc_q  <= {{DATA_W{1'b0}}, mag_a};
      quot_q <= mag_a;
      rem_q  <= '0;
      opb_q  <= mag_b;
    end else if (step) begin
      cnt_q  <= cnt_q + 1'b1;
      acc_q  <= acc_nxt;
      quot_q <= quot_nxt;
      rem_q  <= rem_nxt;
    end
  end

  assign last = (cnt_q == CNT_W'(ITER - 1));
  assign prod = acc_q;
  assign quot = quot_q;
  assign rem  = rem_q[DATA_W-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide: FSM, sign handling, divide special cases and pipeline stall.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            valid_o,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t state_q, state_d;

  logic [2:0]        f3_q;
  logic [4:0]        rd_q, rd_last_q;
  logic              neg_q, spec_q;
  logic [XLEN-1:0]   spec_res_q, res_q;
  logic              accept, signed_a, signed_b, sa, sb, neg_in;
  logic              div_by0, div_ovf, special;
  logic signed [XLEN-1:0] a_s, b_s;
  logic [XLEN-1:0]   mag_a, mag_b, spec_val, final_res;
  logic              iter_last;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  function automatic logic [XLEN-1:0] fix_result(input logic [2:0] f3, input logic neg,
                                                 input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] r);
    logic [2*XLEN-1:0] p_s;
    logic [XLEN-1:0]   res;
    p_s = neg ? -p : p;
    case (f3)
      F3_MUL:          res = p_s[XLEN-1:0];
      F3_DIV, F3_DIVU: res = neg ? -q : q;
      F3_REM, F3_REMU: res = neg ? -r : r;
      default:         res = p_s[2*XLEN-1:XLEN];
    endcase
    return res;
  endfunction

  assign a_s      = op_a;
  assign b_s      = op_b;
  assign signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                    (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign sa       = signed_a && (a_s < 0);
  assign sb       = signed_b && (b_s < 0);
  assign mag_a    = sa ? -op_a : op_a;
  assign mag_b    = sb ? -op_b : op_b;
  assign neg_in   = (funct3 == F3_REM) ? sa : (sa ^ sb);

  assign div_by0  = funct3[2] && (op_b == '0);
  assign div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == INT_MIN) && (op_b == '1);
  assign special  = div_by0 || div_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU among divide ops.
  always_comb begin
    spec_val = '0;
    if (div_by0) spec_val = funct3[1] ? op_a : '1;
    else         spec_val = funct3[1] ? '0 : INT_MIN;
  end

  assign accept = (state_q == ST_IDLE) && start && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (flush)          state_d = ST_IDLE;
        else if (iter_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
    end else if (accept) begin
      f3_q       <= funct3;
      rd_q       <= rd;
      neg_q      <= neg_in;
      spec_q     <= special;
      spec_res_q <= spec_val;
    end
  end

  muldiv_iter #(.DATA_W(XLEN)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .load  (accept && !special),
    .step  (state_q == ST_BUSY),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .last  (iter_last),
    .prod  (prod),
    .quot  (quot),
    .rem   (rem)
  );

  assign final_res = spec_q ? spec_res_q : fix_result(f3_q, neg_q, prod, quot, rem);
  assign valid_o   = (state_q == ST_DONE) && !flush;
  assign busy      = (state_q == ST_BUSY);
  assign stall_req = accept || busy;

  // Outputs show the live result only while valid_o; otherwise the last delivered one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q     <= '0;
      rd_last_q <= '0;
    end else if (valid_o) begin
      res_q     <= final_res;
      rd_last_q <= rd_q;
    end
  end

  assign result = valid_o ? final_res : res_q;
  assign rd_o   = valid_o ? rd_q : rd_last_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: directed RV32M vectors, latency, stall, flush and reset checks.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd;
  logic        stall_req, busy, valid_o;
  logic [31:0] result;
  logic [4:0]  rd_o;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd(rd), .flush(flush), .stall_req(stall_req), .busy(busy), .valid_o(valid_o),
    .result(result), .rd_o(rd_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          at;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (valid_o === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got result %h rd %0d expected no pulse", result, rd_o);
        end else begin
          e = q.pop_front();
          check({e.name, "_res"}, result, e.res);
          check({e.name, "_rd"}, {27'b0, rd_o}, {27'b0, e.rd});
          check({e.name, "_cycle"}, 32'(cyc), 32'(e.at));
        end
      end
    end
  end

  task automatic drive_start(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] r);
    @(negedge clk);
    funct3 = f3; op_a = a; op_b = b; rd = r; start = 1'b1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0; op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D; rd = 5'd31; funct3 = 3'b000;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout_%s: got %0d pending results expected 0", q[0].name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] expv, input int lat);
    drive_start(f3, a, b, r);
    q.push_back('{res: expv, rd: r, at: cyc + lat, name: name});
    release_start();
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd = '0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_result", result, 32'h0);
    check("reset_rd_o", {27'b0, rd_o}, 32'h0);
    check("reset_flags", {29'b0, valid_o, busy, stall_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // MUL with stall_req tracked across the whole operation.
    drive_start(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd1);
    n = cyc;
    q.push_back('{res: 32'hFFFFFFEB, rd: 5'd1, at: n + 33, name: "mul"});
    #1;
    check("mul_stall_accept", {31'b0, stall_req}, 32'h1);
    release_start();
    for (int i = 1; i <= 32; i++) begin
      #1;
      check("mul_stall_busy", {30'b0, stall_req, busy}, 32'h3);
      @(negedge clk);
    end
    #1;
    check("mul_stall_done", {30'b0, stall_req, busy}, 32'h0);
    wait_idle();

    run_op("mulh",   F3_MULH,   32'h80000000, 32'h80000000, 5'd2, 32'h40000000, 33);
    run_op("mulhu",  F3_MULHU,  32'h80000000, 32'h80000000, 5'd3, 32'h40000000, 33);
    run_op("mulhsu", F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd4, 32'hFFFFFFFF, 33);
    run_op("mulh_neg", F3_MULH, 32'hFFFFFFFD, 32'd5,        5'd14, 32'hFFFFFFFF, 33);
    run_op("mul_lo", F3_MUL,    32'h12345678, 32'h10,       5'd15, 32'h23456780, 33);
    run_op("div",    F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd5, 32'hFFFFFFFD, 33);
    run_op("rem",    F3_REM,    32'hFFFFFFF9, 32'd2,        5'd6, 32'hFFFFFFFF, 33);
    run_op("div_nb", F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 33);
    run_op("rem_nb", F3_REM,    32'd7,        32'hFFFFFFFE, 5'd17, 32'h00000001, 33);
    run_op("divu",   F3_DIVU,   32'd100,      32'd7,        5'd7, 32'd14, 33);
    run_op("remu",   F3_REMU,   32'd100,      32'd7,        5'd8, 32'd2, 33);
    #1;
    check("hold_result", result, 32'd2);
    check("hold_rd_o", {27'b0, rd_o}, 32'd8);

    run_op("divu_by0", F3_DIVU, 32'd100,      32'd0,        5'd10, 32'hFFFFFFFF, 1);
    run_op("remu_by0", F3_REMU, 32'd5,        32'd0,        5'd13, 32'd5, 1);
    run_op("rem_ovf",  F3_REM,  32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h0, 1);
    run_op("div_ovf",  F3_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1);

    // DIV squashed by flush in its tenth cycle: no pulse may follow.
    drive_start(F3_DIV, 32'd100, 32'd7, 5'd20);
    release_start();
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle", {29'b0, valid_o, busy, stall_req}, 32'h0);
    repeat (40) @(negedge clk);

    // Reset in the middle of a MUL, then a fresh MULHU.
    drive_start(F3_MUL, 32'd3, 32'd5, 5'd3);
    release_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_flags", {29'b0, valid_o, busy, stall_req}, 32'h0);
    check("midrst_result", result, 32'h0);
    check("midrst_rd_o", {27'b0, rd_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op("mulhu_after_rst", F3_MULHU, 32'd3, 32'd5, 5'd9, 32'h0, 33);
    repeat (40) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
